// File: rtl/parallel_serial.sv
// Byte-to-bit serialiser with a one-byte holding register, MSB first, framed every 8 enb cycles.
// Build option: define PARALLEL_SERIAL_IDLE_EN to send IDLE_SYMBOL as filler instead of 8'h00.
module parallel_serial #(
    parameter logic [7:0] IDLE_SYMBOL = 8'hBC
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       enb,
    input  logic [7:0] data_in,
    input  logic       valid_in,
    output logic       ready_out,
    output logic       serial_out,
    output logic       frame_start,
    output logic       data_active
);

`ifdef PARALLEL_SERIAL_IDLE_EN
    localparam logic [7:0] FILL = IDLE_SYMBOL;
`else
    localparam logic [7:0] FILL = IDLE_SYMBOL & 8'h00;
`endif

    logic [2:0] cnt_q, cnt_d;
    logic [7:0] shifter_q, shifter_d;
    logic [7:0] hold_q, hold_d;
    logic       hold_valid_q, hold_valid_d;
    logic       serial_q, serial_d;
    logic       fs_q, fs_d;
    logic       active_q, active_d;
    logic       boundary;
    logic [7:0] next_byte;

    assign ready_out   = ~hold_valid_q;
    assign serial_out  = serial_q;
    assign frame_start = fs_q;
    assign data_active = active_q;

    assign boundary  = enb && (cnt_q == 3'd0);
    assign next_byte = hold_valid_q ? hold_q : FILL;

    always_comb begin
        cnt_d        = cnt_q;
        shifter_d    = shifter_q;
        hold_d       = hold_q;
        hold_valid_d = hold_valid_q;
        serial_d     = serial_q;
        active_d     = active_q;
        fs_d         = 1'b0;
        if (enb) begin
            // Counting down from 0 wraps to 7, giving a boundary every 8 enb edges.
            cnt_d = cnt_q - 3'd1;
            if (boundary) begin
                serial_d     = next_byte[7];
                shifter_d    = {next_byte[6:0], 1'b0};
                active_d     = hold_valid_q;
                fs_d         = 1'b1;
                hold_valid_d = 1'b0;
            end else begin
                serial_d  = shifter_q[7];
                shifter_d = {shifter_q[6:0], 1'b0};
            end
        end
        // A capture only happens while empty, so it never collides with the boundary clear.
        if (valid_in && ready_out) begin
            hold_d       = data_in;
            hold_valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q        <= 3'd0;
            shifter_q    <= 8'h00;
            hold_q       <= 8'h00;
            hold_valid_q <= 1'b0;
            serial_q     <= 1'b0;
            fs_q         <= 1'b0;
            active_q     <= 1'b0;
        end else begin
            cnt_q        <= cnt_d;
            shifter_q    <= shifter_d;
            hold_q       <= hold_d;
            hold_valid_q <= hold_valid_d;
            serial_q     <= serial_d;
            fs_q         <= fs_d;
            active_q     <= active_d;
        end
    end

endmodule

// File: tb/tb_parallel_serial.sv
// Bench for parallel_serial: frame-level model checked every cycle plus literal frame checks.
module tb_parallel_serial;

`ifdef PARALLEL_SERIAL_IDLE_EN
    localparam logic [7:0] FILL = 8'hBC;
`else
    localparam logic [7:0] FILL = 8'h00;
`endif

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       enb = 1'b0;
    logic [7:0] data_in = 8'h00;
    logic       valid_in = 1'b0;
    logic       ready_out, serial_out, frame_start, data_active;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    parallel_serial #(.IDLE_SYMBOL(8'hBC)) dut (
        .clk(clk), .reset(reset), .enb(enb), .data_in(data_in), .valid_in(valid_in),
        .ready_out(ready_out), .serial_out(serial_out), .frame_start(frame_start),
        .data_active(data_active)
    );

    // Model state: position in frame comes from the count of enb edges since reset.
    logic       m_hv = 1'b0, m_bit = 1'b0, m_fs = 1'b0, m_act = 1'b0;
    logic [7:0] m_hold = 8'h00, m_byte = 8'h00;
    int         m_cnt = 0;
    logic       last_enb = 1'b0, m_rst = 1'b1;

    // Frames reassembled from the DUT output stream.
    logic [7:0] frm_q[$];
    logic       act_q[$];
    logic [7:0] fb = 8'h00;
    logic       fa = 1'b0;
    int         nb = 8;

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
        end
    endtask

    initial forever begin
        logic acc;
        int   pos;
        @(posedge clk);
        m_rst = reset;
        if (reset) begin
            m_hv = 0; m_cnt = 0; m_bit = 0; m_fs = 0; m_act = 0; last_enb = 0;
        end else begin
            acc      = valid_in && !m_hv;
            m_fs     = 0;
            last_enb = enb;
            if (enb) begin
                pos = m_cnt % 8;
                if (pos == 0) begin
                    if (m_hv) begin
                        m_byte = m_hold; m_act = 1; m_hv = 0;
                    end else begin
                        m_byte = FILL; m_act = 0;
                    end
                    m_fs = 1;
                end
                m_bit = m_byte[7-pos];
                m_cnt++;
            end
            if (acc) begin
                m_hold = data_in; m_hv = 1;
            end
        end
    end

    initial forever begin
        @(negedge clk);
        chk("serial_out", {7'd0, serial_out}, {7'd0, m_bit});
        chk("frame_start", {7'd0, frame_start}, {7'd0, m_fs});
        chk("data_active", {7'd0, data_active}, {7'd0, m_act});
        chk("ready_out", {7'd0, ready_out}, {7'd0, !m_hv});
        if (m_rst) nb = 8;
        else begin
            if (frame_start) begin
                nb = 0; fb = 8'h00; fa = data_active;
            end
            if (last_enb && nb < 8) begin
                fb = {fb[6:0], serial_out};
                nb++;
                if (nb == 8) begin
                    frm_q.push_back(fb);
                    act_q.push_back(fa);
                end
            end
        end
    end

    int mode = 0;
    int div = 0;

    task automatic tick(input int n);
        repeat (n) begin
            @(negedge clk);
            if (mode == 0) enb = 1'b1;
            else begin
                enb = (div == 9);
                div = (div + 1) % 10;
            end
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1; valid_in = 1'b0;
        tick(1);
        frm_q.delete(); act_q.delete();
        tick(1);
        chk("reset serial_out", {7'd0, serial_out}, 8'd0);
        chk("reset frame_start", {7'd0, frame_start}, 8'd0);
        chk("reset data_active", {7'd0, data_active}, 8'd0);
        chk("reset ready_out", {7'd0, ready_out}, 8'd1);
        reset = 1'b0;
        div = 0;
        enb = (mode == 0);
    endtask

    task automatic send(input logic [7:0] b);
        logic r;
        logic done;
        done = 0;
        valid_in = 1'b1; data_in = b;
        for (int t = 0; t < 200 && !done; t++) begin
            r = ready_out;
            tick(1);
            done = r;
        end
        valid_in = 1'b0;
        checks++;
        if (!done) begin
            errors++;
            $display("FAIL send_timeout actual=not_accepted expected=accepted byte=%h", b);
        end
    endtask

    task automatic chkf(input int idx, input logic [7:0] exp, input logic exp_act);
        checks++;
        if (idx >= frm_q.size()) begin
            errors++;
            $display("FAIL frame%0d_missing actual=%0d frames expected=>%0d", idx, frm_q.size(), idx);
        end else begin
            checks--;
            chk($sformatf("frame%0d_byte", idx), frm_q[idx], exp);
            chk($sformatf("frame%0d_active", idx), {7'd0, act_q[idx]}, {7'd0, exp_act});
        end
    endtask

    initial begin
        // Idle link: filler frames only.
        mode = 0;
        do_reset();
        tick(26);
        chkf(0, FILL, 0); chkf(1, FILL, 0); chkf(2, FILL, 0);

        // Single byte offered at reset release waits one filler frame.
        do_reset();
        valid_in = 1'b1; data_in = 8'hA5;
        tick(1);
        valid_in = 1'b0;
        chk("A5 ready_low", {7'd0, ready_out}, 8'd0);
        tick(26);
        chkf(0, FILL, 0); chkf(1, 8'hA5, 1); chkf(2, FILL, 0);

        // Back-to-back bytes with valid held.
        do_reset();
        send(8'h01); send(8'h80); send(8'hFF);
        tick(24);
        chkf(0, FILL, 0); chkf(1, 8'h01, 1); chkf(2, 8'h80, 1); chkf(3, 8'hFF, 1); chkf(4, FILL, 0);

        // Sparse enb: one enable every 10 clocks.
        mode = 1;
        do_reset();
        send(8'h3C);
        tick(175);
        chkf(0, 8'h3C, 1); chkf(1, FILL, 0);

        // Reset mid-frame discards both the shifting and held bytes.
        mode = 0;
        do_reset();
        send(8'hC3); send(8'h5A);
        tick(2);
        reset = 1'b1;
        tick(1);
        frm_q.delete(); act_q.delete();
        reset = 1'b0;
        chk("mid_reset ready_out", {7'd0, ready_out}, 8'd1);
        chk("mid_reset serial_out", {7'd0, serial_out}, 8'd0);
        tick(18);
        chkf(0, FILL, 0); chkf(1, FILL, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/parallel_serial.md
PARALLEL_SERIAL -- requirements
Module: parallel_serial

Interface
REQ-001 The block SHALL have parameter IDLE_SYMBOL, default 8'hBC, meaning the byte transmitted when no data byte is pending.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 reset  input  1  synchronous, active-high reset, sampled on clk.
REQ-004 enb  input  1  bit-rate enable; one serial bit is advanced per clk edge with enb=1.
REQ-005 data_in  input  8  parallel byte offered by the producer.
REQ-006 valid_in  input  1  data_in is valid this cycle.
REQ-007 ready_out  output  1  holding register empty; a byte can be accepted this cycle.
REQ-008 serial_out  output  1  registered serial bit stream, MSB first.
REQ-009 frame_start  output  1  one-cycle pulse marking the cycle in which serial_out first shows bit 7 of a new byte.
REQ-010 data_active  output  1  high while the byte being shifted came from data_in; low for idle or filler bytes.

Function
REQ-011 ready_out SHALL equal the inverse of the hold_valid register, with no combinational path from valid_in.
REQ-012 On any clk edge with valid_in=1 and ready_out=1, data_in SHALL be captured into the holding register and hold_valid set, independent of enb.
REQ-013 A 3-bit bit counter cnt SHALL hold its value on edges with enb=0 and advance only on edges with enb=1.
REQ-014 The advance sequence SHALL be 0 -> 7 -> 6 -> ... -> 1 -> 0.
REQ-015 An enb=1 edge with cnt==0 is a boundary, so boundaries SHALL recur every 8 enb cycles.
REQ-016 At a boundary with hold_valid=1, next_byte SHALL be the holding register and hold_valid SHALL be cleared.
REQ-017 At a boundary with hold_valid=0, next_byte SHALL be the filler byte defined by REQ-026 or REQ-027.
REQ-018 At a boundary, serial_out SHALL take next_byte[7], shifter SHALL take {next_byte[6:0],1'b0}, and data_active SHALL take hold_valid.
REQ-019 On a non-boundary enb=1 edge, serial_out SHALL take shifter[7] and shifter SHALL shift left by one.
REQ-020 The bit order on serial_out SHALL be b7, b6, ..., b0, one bit per enb cycle.
REQ-021 frame_start SHALL be 1 in the cycle following a boundary edge and 0 in all other cycles, including while enb=0.
REQ-022 A capture on a boundary edge while hold_valid=0 SHALL NOT be transmitted in that frame; the byte waits for the next boundary (no bypass).
REQ-023 A capture in the same edge that clears hold_valid cannot occur, because ready_out was 0 during that cycle.
REQ-024 Latency SHALL be one clk edge from acceptance to hold_valid, and at most 8 enb cycles plus 1 clk edge from acceptance to that byte's bit 7 appearing on serial_out.
REQ-025 A byte loaded into the shifter SHALL complete all 8 bits; there is no abort path except reset.

Configuration
REQ-026 With macro PARALLEL_SERIAL_IDLE_EN defined, the filler byte SHALL be IDLE_SYMBOL.
REQ-027 With PARALLEL_SERIAL_IDLE_EN undefined, the filler byte SHALL be 8'h00, and IDLE_SYMBOL SHALL be ignored.
REQ-028 data_active SHALL be 0 for filler bytes in both builds.

Reset
REQ-029 While reset=1, the following SHALL be cleared: cnt=0, shifter=0, hold_valid=0 (ready_out=1), serial_out=0, frame_start=0, data_active=0.
REQ-030 Reset SHALL take priority over enb, valid_in, and any boundary event.
REQ-031 Reset asserted mid-byte SHALL discard the byte in transmission and any held byte.
REQ-032 The first enb=1 edge after reset deassertion SHALL be a boundary.

Verification
REQ-033 Reset, then enb=1 continuously with no valid_in (IDLE_EN defined) -> serial_out repeats 1,0,1,1,1,1,0,0; frame_start pulses every 8 cycles; data_active=0.
REQ-034 Offer 8'hA5 at reset release, enb=1 continuously -> ready_out=0 for one frame; next frame serial_out = 1,0,1,0,0,1,0,1 with data_active=1; then idle resumes.
REQ-035 Hold valid_in=1 with bytes 8'h01, 8'h80, 8'hFF -> each accepted exactly once; ready_out low about 8 enb cycles per byte; the stream shows the three bytes back-to-back with no idle between them.
REQ-036 Assert enb only every 10th clk with byte 8'h3C -> cnt and serial_out are stable between enb pulses; frame_start is a single-clk pulse; bits are 0,0,1,1,1,1,0,0.
REQ-037 Assert reset for one cycle at cnt=4 during 8'hC3 with 8'h5A held -> all outputs return to reset values; 8'h5A is never transmitted; the next frame is filler.
REQ-038 Build without PARALLEL_SERIAL_IDLE_EN and leave the link empty -> serial_out constant 0; frame_start still pulses every 8 enb cycles.
